// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch front end and decode.
//   fetch_state_t : fetch FSM states
//   fq_entry_t    : fetch-queue entry {pc, inst} at the default widths
//   FETCH_STRIDE  : default PC increment per instruction (bytes)
package fetch_pkg;

    localparam int FETCH_ADDR_W = 64;
    localparam int FETCH_INST_W = 32;
    localparam int FETCH_STRIDE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_INST_W-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries.
//   clk, rst_n     : clock, async active-low reset
//   flush          : empty the queue (wins over push/pop)
//   push, wdata    : enqueue one entry (ignored when full and not popping)
//   pop            : dequeue head (ignored when empty)
//   empty, rdata   : head status / head entry
//   count          : occupied entries, 0..DEPTH
// Pointers carry one extra MSB so full and empty are distinguishable.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fq_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   wdata,
    input  logic                     pop,
    output logic                     empty,
    output entry_t                   rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   clk, reset_n            : clock, async active-low reset (pc loads entry while low)
//   entry                   : reset PC
//   ic_req, ic_addr         : one word-fetch request, held until accepted (!ic_busy)
//   ic_resp_valid/data      : response pulse for the single outstanding request
//   redirect, redirect_pc   : flush + new PC (low two bits ignored)
//   dec_valid/ready/pc/inst : fetch-queue head presented to decode
//   fq_count                : fetch-queue occupancy
// At most one request is outstanding. A request is only issued when the queue
// has room for its response, so a full queue parks the FSM in IDLE.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int INST_W   = FETCH_INST_W,
    parameter int FQ_DEPTH = 4,
    parameter int STRIDE   = FETCH_STRIDE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         entry,
    output logic                      ic_req,
    output logic [ADDR_W-1:0]         ic_addr,
    input  logic                      ic_busy,
    input  logic                      ic_resp_valid,
    input  logic [INST_W-1:0]         ic_resp_data,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [ADDR_W-1:0]         dec_pc,
    output logic [INST_W-1:0]         dec_inst,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;

    logic              accept;
    logic              fq_push;
    logic              fq_pop;
    logic              fq_empty;
    entry_t            fq_wdata;
    entry_t            fq_rdata;
    logic [CW-1:0]     fq_cnt;
    logic [CW-1:0]     cnt_next;
    logic              credit;

    assign ic_req  = (state_q == REQ);
    assign ic_addr = pc_q;
    assign accept  = ic_req && !ic_busy;

    // Redirect kills both the arriving response and the decode handshake.
    assign fq_push  = (state_q == WAIT) && ic_resp_valid && !drop_q && !redirect;
    assign fq_pop   = dec_valid && dec_ready && !redirect;
    assign fq_wdata = '{pc: pc_q, inst: ic_resp_data};

    // Credit is consulted only where nothing is outstanding after this edge,
    // so the projected occupancy alone decides whether a new fetch fits.
    assign cnt_next = fq_cnt + CW'(fq_push) - CW'(fq_pop);
    assign credit   = (cnt_next < CW'(FQ_DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        if (redirect) begin
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            // A request still owed a response (waiting, or accepted right now)
            // will return stale data: park in WAIT and discard it.
            if (((state_q == WAIT) && !ic_resp_valid) || accept) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = REQ;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (credit) state_d = REQ;
                end
                REQ: begin
                    if (accept) state_d = WAIT;
                end
                WAIT: begin
                    if (ic_resp_valid) begin
                        if (!drop_q) pc_d = pc_q + ADDR_W'(STRIDE);
                        drop_d  = 1'b0;
                        state_d = credit ? REQ : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= entry;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (entry_t)
    ) u_fq (
        .clk   (clk),
        .rst_n (reset_n),
        .flush (redirect),
        .push  (fq_push),
        .wdata (fq_wdata),
        .pop   (fq_pop),
        .empty (fq_empty),
        .rdata (fq_rdata),
        .count (fq_cnt)
    );

    assign dec_valid = !fq_empty;
    assign dec_pc    = dec_valid ? fq_rdata.pc   : '0;
    assign dec_inst  = dec_valid ? fq_rdata.inst : '0;
    assign fq_count  = fq_cnt;

endmodule
